// File: rtl/relu_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool_stage
// Purpose  : ReLU followed by 2x2 stride-2 max-pooling over a raster-ordered
//            convolution output map. One pooled value is emitted per 2x2
//            window. A half-width line buffer carries partial maxima from each
//            even conv row to the following odd row.
// Ports    : clock_i           - rising-edge clock
//            reset_i           - synchronous, active-high reset
//            dotproduct_i      - signed 32-bit conv result
//            dotproductReady_i - one-cycle strobe qualifying dotproduct_i
//            pooled_o          - pooled value (never negative), held between strobes
//            pooledValid_o     - one-cycle strobe qualifying pooled_o
//            frameDone_o       - one-cycle strobe after the last sample of a frame
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool_stage #(
    parameter int CONV_WIDTH  = 9,
    parameter int CONV_HEIGHT = 9
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] dotproduct_i,
    input  logic        dotproductReady_i,
    output logic [31:0] pooled_o,
    output logic        pooledValid_o,
    output logic        frameDone_o
);

    localparam int POOL_COLS = CONV_WIDTH / 2;
    localparam int POOL_ROWS = CONV_HEIGHT / 2;
    // Counter widths sized so the values 0..CONV_WIDTH (inclusive) fit, which
    // also lets the window bounds be expressed in the counter width.
    localparam int CW = $clog2(CONV_WIDTH + 1);
    localparam int RW = $clog2(CONV_HEIGHT + 1);
    localparam int IW = (POOL_COLS > 1) ? $clog2(POOL_COLS) : 1;

    typedef enum logic [0:0] {
        EVEN_ROW = 1'b0,
        ODD_ROW  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [31:0]   hold_q, hold_d;
    logic [31:0]   pooled_q, pooled_d;
    logic          pooledValid_q, pooledValid_d;
    logic          frameDone_q, frameDone_d;

    logic [31:0]   line_q [POOL_COLS];
    logic          line_we_d;
    logic [31:0]   line_wdata_d;

    logic [31:0]   relu;
    logic [IW-1:0] line_idx;
    logic          last_col;
    logic          last_row;
    logic          in_window;

    function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    assign relu      = dotproduct_i[31] ? 32'd0 : dotproduct_i;
    // Only in-window columns reach the buffer, so col>>1 < POOL_COLS there.
    assign line_idx  = IW'(col_q >> 1);
    assign last_col  = (col_q == CW'(CONV_WIDTH - 1));
    assign last_row  = (row_q == RW'(CONV_HEIGHT - 1));
    assign in_window = (col_q < CW'(2 * POOL_COLS)) && (row_q < RW'(2 * POOL_ROWS));

    always_comb begin
        state_d       = state_q;
        col_d         = col_q;
        row_d         = row_q;
        hold_d        = hold_q;
        pooled_d      = pooled_q;
        pooledValid_d = 1'b0;
        frameDone_d   = 1'b0;
        line_we_d     = 1'b0;
        line_wdata_d  = umax(hold_q, relu);

        if (dotproductReady_i) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : row_q + 1'b1;
                // A frame always restarts on an even row, even when the
                // height is odd and the final row would otherwise toggle.
                if (last_row) begin
                    state_d = EVEN_ROW;
                end else begin
                    state_d = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
                end
            end
            frameDone_d = last_col && last_row;

            if (in_window) begin
                case (state_q)
                    EVEN_ROW: begin
                        if (!col_q[0]) begin
                            hold_d = relu;
                        end else begin
                            line_we_d = 1'b1;
                        end
                    end
                    ODD_ROW: begin
                        if (!col_q[0]) begin
                            hold_d = umax(line_q[line_idx], relu);
                        end else begin
                            pooled_d      = umax(hold_q, relu);
                            pooledValid_d = 1'b1;
                        end
                    end
                    default: begin
                        state_d = EVEN_ROW;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= EVEN_ROW;
            col_q         <= '0;
            row_q         <= '0;
            hold_q        <= '0;
            pooled_q      <= '0;
            pooledValid_q <= 1'b0;
            frameDone_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_q         <= col_d;
            row_q         <= row_d;
            hold_q        <= hold_d;
            pooled_q      <= pooled_d;
            pooledValid_q <= pooledValid_d;
            frameDone_q   <= frameDone_d;
        end
    end

    // Line buffer has no reset: every even row rewrites an entry before the
    // following odd row reads it.
    always_ff @(posedge clock_i) begin
        if (!reset_i && line_we_d) begin
            line_q[line_idx] <= line_wdata_d;
        end
    end

    assign pooled_o      = pooled_q;
    assign pooledValid_o = pooledValid_q;
    assign frameDone_o   = frameDone_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool_stage
// Purpose  : Scoreboard bench for relu_maxpool_stage. Three shapes are
//            instantiated (4x2, 4x4, 9x9); one is selected at a time. A
//            positional reference model pushes expected pooled values and
//            frameDone cycles as samples are driven; a monitor pops and
//            compares them when the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool_stage;

    logic        clk;
    logic        rst;
    logic [31:0] dp;
    logic        rdy;
    logic [1:0]  sel;
    logic [2:0]  rdy_v;

    logic [31:0] pooled_v [3];
    logic        pv_v     [3];
    logic        fd_v     [3];

    logic [31:0] m_pooled;
    logic        m_pv;
    logic        m_fd;

    int cyc;
    int n_cmp;
    int n_err;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t q_pool [$];
    int   q_fd   [$];

    int          W;
    int          H;
    int          tb_row;
    int          tb_col;
    logic [31:0] frame_r [9][9];

    assign rdy_v    = rdy ? (3'b001 << sel) : 3'b000;
    assign m_pooled = pooled_v[sel];
    assign m_pv     = pv_v[sel];
    assign m_fd     = fd_v[sel];

    relu_maxpool_stage #(.CONV_WIDTH(4), .CONV_HEIGHT(2)) u_dut_42 (
        .clock_i(clk), .reset_i(rst), .dotproduct_i(dp), .dotproductReady_i(rdy_v[0]),
        .pooled_o(pooled_v[0]), .pooledValid_o(pv_v[0]), .frameDone_o(fd_v[0])
    );

    relu_maxpool_stage #(.CONV_WIDTH(4), .CONV_HEIGHT(4)) u_dut_44 (
        .clock_i(clk), .reset_i(rst), .dotproduct_i(dp), .dotproductReady_i(rdy_v[1]),
        .pooled_o(pooled_v[1]), .pooledValid_o(pv_v[1]), .frameDone_o(fd_v[1])
    );

    relu_maxpool_stage u_dut_99 (
        .clock_i(clk), .reset_i(rst), .dotproduct_i(dp), .dotproductReady_i(rdy_v[2]),
        .pooled_o(pooled_v[2]), .pooledValid_o(pv_v[2]), .frameDone_o(fd_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_relu(input logic [31:0] v);
        return v[31] ? 32'd0 : v;
    endfunction

    function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        logic [31:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Monitor: compare strobes against the scoreboard heads on the falling edge.
    always @(negedge clk) begin
        if (q_pool.size() > 0 && q_pool[0].cyc == cyc) begin
            check_eq("pooledValid", 32'(m_pv), 32'd1);
            if (m_pv) check_eq("pooled", m_pooled, q_pool[0].val);
            void'(q_pool.pop_front());
        end else if (m_pv) begin
            check_eq("pooledValid_unexpected", 32'(m_pv), 32'd0);
        end
        if (q_fd.size() > 0 && q_fd[0] == cyc) begin
            check_eq("frameDone", 32'(m_fd), 32'd1);
            void'(q_fd.pop_front());
        end else if (m_fd) begin
            check_eq("frameDone_unexpected", 32'(m_fd), 32'd0);
        end
    end

    task automatic set_shape(input logic [1:0] s);
        sel = s;
        case (s)
            2'd0:    begin W = 4; H = 2; end
            2'd1:    begin W = 4; H = 4; end
            default: begin W = 9; H = 9; end
        endcase
        tb_row = 0;
        tb_col = 0;
    endtask

    // Reference model: record the ReLU'd sample at its raster position and,
    // on a window's bottom-right sample, push the max of the four.
    task automatic model_sample(input logic [31:0] v);
        frame_r[tb_row][tb_col] = ref_relu(v);
        if ((tb_row % 2 == 1) && (tb_col % 2 == 1) &&
            (tb_row < 2 * (H / 2)) && (tb_col < 2 * (W / 2))) begin
            exp_t e;
            e.val = max4(frame_r[tb_row-1][tb_col-1], frame_r[tb_row-1][tb_col],
                         frame_r[tb_row][tb_col-1],   frame_r[tb_row][tb_col]);
            e.cyc = cyc + 1;
            q_pool.push_back(e);
        end
        if (tb_row == H - 1 && tb_col == W - 1) q_fd.push_back(cyc + 1);
        if (tb_col == W - 1) begin
            tb_col = 0;
            tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
        end else begin
            tb_col = tb_col + 1;
        end
    endtask

    task automatic send(input logic [31:0] v, input int gap);
        repeat (gap) begin
            @(posedge clk); #1;
            rdy = 1'b0;
        end
        @(posedge clk); #1;
        dp  = v;
        rdy = 1'b1;
        model_sample(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            rdy = 1'b0;
        end
    endtask

    task automatic do_reset(input logic with_sample);
        @(posedge clk); #1;
        rst = 1'b1;
        rdy = with_sample;
        dp  = 32'd12345;
        @(posedge clk); #1;
        rdy = 1'b0;
        @(posedge clk); #1;
        rst    = 1'b0;
        tb_row = 0;
        tb_col = 0;
        check_eq("rst_pooled", m_pooled, 32'd0);
        check_eq("rst_pooledValid", 32'(m_pv), 32'd0);
        check_eq("rst_frameDone", 32'(m_fd), 32'd0);
    endtask

    function automatic logic [31:0] rand_sample();
        logic [31:0] v;
        v = $urandom;
        // Mostly non-negative values so maxima are interesting; some negatives.
        if ($urandom_range(0, 3) != 0) v[31] = 1'b0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t_pos [8];
        logic [31:0] t_neg [8];
        t_pos = '{32'd1, 32'd5, 32'd2, 32'd3, 32'd4, 32'd0, 32'd7, 32'd6};
        t_neg = '{32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FF9C,
                  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'hFFFF_0000};
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        rdy = 1'b0;
        dp  = '0;

        // 4x2: known values, then all-negative frame.
        set_shape(2'd0);
        do_reset(1'b0);
        for (int i = 0; i < 8; i++) send(t_pos[i], 0);
        idle(3);
        for (int i = 0; i < 8; i++) send(t_neg[i], 0);
        idle(3);

        // 9x9 ramp back-to-back.
        set_shape(2'd2);
        do_reset(1'b0);
        for (int i = 0; i < 81; i++) send(32'(i), 0);
        idle(3);

        // Two 9x9 frames of random data with random gaps.
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 81; i++) send(rand_sample(), $urandom_range(0, 5));
        end
        idle(3);

        // 4x4: reset partway through a frame, with a sample on the reset cycle.
        set_shape(2'd1);
        do_reset(1'b0);
        for (int i = 0; i < 13; i++) send(rand_sample(), 0);
        idle(2);
        check_eq("sb_empty_before_reset", 32'(q_pool.size()), 32'd0);
        do_reset(1'b1);
        for (int i = 0; i < 16; i++) send(rand_sample(), $urandom_range(0, 2));
        idle(4);

        check_eq("sb_pool_drained", 32'(q_pool.size()), 32'd0);
        check_eq("sb_fd_drained", 32'(q_fd.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
